// File: rtl/alu_arbiter.sv
// Purpose : shares one 32-bit alu between two valid/ready requesters, each with its own registered response slot.
// Latency : 1 cycle from the request grant to rsp_valid.
//           Up to 1 op/cycle per port when that port is uncontended.
// Backpress: a port whose slot is full and not being consumed is not eligible, and the other port may take the alu.
//
// Ports (pN_ = p0_ / p1_):
//   clk, reset                          clock, synchronous active-high reset
//   pN_req_valid / pN_req_ready         request handshake; ready is combinational (the grant)
//   pN_SrcA, pN_SrcB, pN_ALUControl     operands and op (000 add, 001 sub, 010 and, 011 or, 101 slt)
//   pN_rsp_valid / pN_rsp_ready         response slot handshake
//   pN_ALUResult, pN_Zero               registered result and zero flag of slot N
//
// Build option: define ALU_ARB_FIXED_PRIO_EN for fixed priority (port0 first) with a port1 starvation guard
// bounded by STARVE_LIMIT. When it is undefined, arbitration is round-robin.
module alu_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        p0_req_valid,
    output logic        p0_req_ready,
    input  logic [31:0] p0_SrcA,
    input  logic [31:0] p0_SrcB,
    input  logic [2:0]  p0_ALUControl,
    output logic        p0_rsp_valid,
    input  logic        p0_rsp_ready,
    output logic [31:0] p0_ALUResult,
    output logic        p0_Zero,
    input  logic        p1_req_valid,
    output logic        p1_req_ready,
    input  logic [31:0] p1_SrcA,
    input  logic [31:0] p1_SrcB,
    input  logic [2:0]  p1_ALUControl,
    output logic        p1_rsp_valid,
    input  logic        p1_rsp_ready,
    output logic [31:0] p1_ALUResult,
    output logic        p1_Zero
);

    typedef struct packed {
        logic [31:0] src_a;
        logic [31:0] src_b;
        logic [2:0]  ctl;
    } alu_op_t;

`ifdef ALU_ARB_FIXED_PRIO_EN
    localparam bit FIXED_PRIO = 1'b1;
`else
    localparam bit FIXED_PRIO = 1'b0;
`endif

    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    logic       elig0, elig1;
    logic       grant0, grant1;
    logic       last_grant;    // 1 = port1 was granted last
    logic [7:0] starve_cnt;
    alu_op_t    op0, op1, alu_in;
    logic [31:0] alu_result;
    logic       alu_zero;

    assign op0 = '{src_a: p0_SrcA, src_b: p0_SrcB, ctl: p0_ALUControl};
    assign op1 = '{src_a: p1_SrcA, src_b: p1_SrcB, ctl: p1_ALUControl};

    // A port can take the alu only if its slot is empty or is being drained this cycle.
    assign elig0 = p0_req_valid && (!p0_rsp_valid || p0_rsp_ready);
    assign elig1 = p1_req_valid && (!p1_rsp_valid || p1_rsp_ready);

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (FIXED_PRIO) begin
            // Port0 wins ties, unless port1 has waited long enough.
            grant1 = elig1 && (!elig0 || (starve_cnt >= LIMIT));
            grant0 = elig0 && !grant1;
        end else if (elig0 && elig1) begin
            // On a tie, the port that did not win last time is granted.
            grant0 = last_grant;
            grant1 = !last_grant;
        end else begin
            grant0 = elig0;
            grant1 = elig1;
        end
    end

    assign p0_req_ready = grant0;
    assign p1_req_ready = grant1;

    // When no port is granted, the alu inputs are held at zero.
    always_comb begin
        alu_in = '0;
        if (grant0) begin
            alu_in = op0;
        end else if (grant1) begin
            alu_in = op1;
        end
    end

    always_comb begin
        alu_result = '0;
        case (alu_in.ctl)
            3'b000:  alu_result = alu_in.src_a + alu_in.src_b;
            3'b001:  alu_result = alu_in.src_a - alu_in.src_b;
            3'b010:  alu_result = alu_in.src_a & alu_in.src_b;
            3'b011:  alu_result = alu_in.src_a | alu_in.src_b;
            3'b101:  alu_result = {31'b0, $signed(alu_in.src_a) < $signed(alu_in.src_b)};
            default: alu_result = '0;
        endcase
    end

    assign alu_zero = (alu_result == 32'd0);

    // A grant overrides a release, so a consume and a re-grant in the same cycle keep the slot valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            p0_rsp_valid <= 1'b0;
            p0_ALUResult <= '0;
            p0_Zero      <= 1'b0;
            p1_rsp_valid <= 1'b0;
            p1_ALUResult <= '0;
            p1_Zero      <= 1'b0;
            last_grant   <= 1'b1;
            starve_cnt   <= '0;
        end else begin
            if (grant0) begin
                p0_rsp_valid <= 1'b1;
                p0_ALUResult <= alu_result;
                p0_Zero      <= alu_zero;
            end else if (p0_rsp_valid && p0_rsp_ready) begin
                p0_rsp_valid <= 1'b0;
            end

            if (grant1) begin
                p1_rsp_valid <= 1'b1;
                p1_ALUResult <= alu_result;
                p1_Zero      <= alu_zero;
            end else if (p1_rsp_valid && p1_rsp_ready) begin
                p1_rsp_valid <= 1'b0;
            end

            if (grant0) begin
                last_grant <= 1'b0;
            end else if (grant1) begin
                last_grant <= 1'b1;
            end

            // Counts the cycles in which port1 could have gone but did not. It saturates at 255.
            if (grant1 || !p1_req_valid) begin
                starve_cnt <= '0;
            end else if (elig1 && (starve_cnt != 8'hFF)) begin
                starve_cnt <= starve_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Purpose : self-checking bench for alu_arbiter with per-port scoreboards of expected responses.
// Latency : the bench samples 1 ns after each falling edge, and it drives inputs on falling edges.
// Backpress: the bench toggles rsp_ready to fill the response slots and to exercise the eligibility rules.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        p0_req_valid, p0_req_ready, p0_rsp_valid, p0_rsp_ready, p0_Zero;
    logic [31:0] p0_SrcA, p0_SrcB, p0_ALUResult;
    logic [2:0]  p0_ALUControl;
    logic        p1_req_valid, p1_req_ready, p1_rsp_valid, p1_rsp_ready, p1_Zero;
    logic [31:0] p1_SrcA, p1_SrcB, p1_ALUResult;
    logic [2:0]  p1_ALUControl;

    alu_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk(clk), .reset(reset),
        .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready),
        .p0_SrcA(p0_SrcA), .p0_SrcB(p0_SrcB), .p0_ALUControl(p0_ALUControl),
        .p0_rsp_valid(p0_rsp_valid), .p0_rsp_ready(p0_rsp_ready),
        .p0_ALUResult(p0_ALUResult), .p0_Zero(p0_Zero),
        .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready),
        .p1_SrcA(p1_SrcA), .p1_SrcB(p1_SrcB), .p1_ALUControl(p1_ALUControl),
        .p1_rsp_valid(p1_rsp_valid), .p1_rsp_ready(p1_rsp_ready),
        .p1_ALUResult(p1_ALUResult), .p1_Zero(p1_Zero)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    logic last_g0, last_g1;
    logic [32:0] q0[$];
    logic [32:0] q1[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference alu. The return value is {zero, result}. For slt, the sign bits decide when the operand signs differ.
    function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] c);
        logic [31:0] r;
        case (c)
            3'd0: r = a + b;
            3'd1: r = a + ~b + 32'd1;
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd5: r = (a[31] != b[31]) ? {31'b0, a[31]} : {31'b0, (a < b)};
            default: r = 32'd0;
        endcase
        return {(r == 32'd0), r};
    endfunction

    // One clock: settle, record grants, run the scoreboards, then advance to the next falling edge.
    task automatic cycle();
        logic [32:0] e;
        #1;
        last_g0 = p0_req_ready;
        last_g1 = p1_req_ready;
        if (!reset) begin
            chk("single_grant", 32'(last_g0 & last_g1), 32'd0);
            if (p0_req_valid && p0_req_ready) q0.push_back(model(p0_SrcA, p0_SrcB, p0_ALUControl));
            if (p1_req_valid && p1_req_ready) q1.push_back(model(p1_SrcA, p1_SrcB, p1_ALUControl));
            if (p0_rsp_valid && p0_rsp_ready) begin
                chk("p0_rsp_expected", 32'(q0.size() != 0), 32'd1);
                if (q0.size() != 0) begin
                    e = q0.pop_front();
                    chk("p0_result", p0_ALUResult, e[31:0]);
                    chk("p0_zero", 32'(p0_Zero), 32'(e[32]));
                end
            end
            if (p1_rsp_valid && p1_rsp_ready) begin
                chk("p1_rsp_expected", 32'(q1.size() != 0), 32'd1);
                if (q1.size() != 0) begin
                    e = q1.pop_front();
                    chk("p1_result", p1_ALUResult, e[31:0]);
                    chk("p1_zero", 32'(p1_Zero), 32'(e[32]));
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        p0_req_valid = 1'b0;
        p1_req_valid = 1'b0;
        p0_rsp_ready = 1'b1;
        p1_rsp_ready = 1'b1;
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        bit exp_g0;
        reset = 1'b1;
        p0_req_valid = 0; p0_SrcA = 0; p0_SrcB = 0; p0_ALUControl = 0; p0_rsp_ready = 0;
        p1_req_valid = 0; p1_SrcA = 0; p1_SrcB = 0; p1_ALUControl = 0; p1_rsp_ready = 0;
        cycle();
        cycle();
        reset = 1'b0;
        chk("rst_p0_rsp_valid", 32'(p0_rsp_valid), 32'd0);
        chk("rst_p1_rsp_valid", 32'(p1_rsp_valid), 32'd0);
        chk("rst_p0_result", p0_ALUResult, 32'd0);
        chk("rst_p1_zero", 32'(p1_Zero), 32'd0);

        // Fill the port0 slot, then reset while the result is still unconsumed.
        p0_req_valid = 1; p0_SrcA = 1; p0_SrcB = 2; p0_ALUControl = 3'b000;
        cycle();
        p0_req_valid = 0;
        chk("mid_p0_rsp_valid", 32'(p0_rsp_valid), 32'd1);
        chk("mid_p0_result", p0_ALUResult, 32'd3);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        q0.delete();
        q1.delete();
        chk("post_rst_p0_rsp_valid", 32'(p0_rsp_valid), 32'd0);
        chk("post_rst_p0_result", p0_ALUResult, 32'd0);

        // Both ports request continuously. The first tie goes to port0.
        // Round-robin then alternates. Fixed priority grants port1 every fifth cycle.
        p0_rsp_ready = 1; p1_rsp_ready = 1;
        p0_req_valid = 1; p0_SrcA = 32'd100; p0_SrcB = 32'd23; p0_ALUControl = 3'b000;
        p1_req_valid = 1; p1_SrcA = 32'd3;   p1_SrcB = 32'd3;  p1_ALUControl = 3'b001;
        for (int k = 0; k < 10; k++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            exp_g0 = ((k % 5) != 4);
`else
            exp_g0 = ((k % 2) == 0);
`endif
            cycle();
            chk($sformatf("tie_g0_%0d", k), 32'(last_g0), 32'(exp_g0));
            chk($sformatf("tie_g1_%0d", k), 32'(last_g1), 32'(!exp_g0));
            if (last_g0) begin
                p0_SrcA = 32'(k * 3 + 1); p0_SrcB = 32'(k); p0_ALUControl = 3'(k % 4);
            end
            if (last_g1) begin
                p1_SrcA = $urandom; p1_SrcB = $urandom; p1_ALUControl = 3'b000;
            end
        end
        idle(2);

        // Port0 alone: the grant comes in the same cycle, and the result is registered 1 cycle later.
        p0_req_valid = 1; p0_SrcA = 32'd5; p0_SrcB = 32'd7; p0_ALUControl = 3'b000;
        cycle();
        chk("p0_only_ready", 32'(last_g0), 32'd1);
        p0_req_valid = 0;
        chk("p0_only_rsp_valid", 32'(p0_rsp_valid), 32'd1);
        chk("p0_only_result", p0_ALUResult, 32'd12);
        chk("p0_only_zero", 32'(p0_Zero), 32'd0);

        // Back-to-back issue on port0 while consuming the slot every cycle.
        p0_req_valid = 1;
        for (int k = 0; k < 4; k++) begin
            p0_SrcA = $urandom; p0_SrcB = $urandom; p0_ALUControl = 3'(k);
            cycle();
            chk($sformatf("b2b_ready_%0d", k), 32'(last_g0), 32'd1);
            chk($sformatf("b2b_rsp_valid_%0d", k), 32'(p0_rsp_valid), 32'd1);
        end
        idle(2);

        // Port0 slot full and not drained: port1 gets the alu every cycle.
        p0_rsp_ready = 0;
        p0_req_valid = 1; p0_SrcA = 32'd10; p0_SrcB = 32'd20; p0_ALUControl = 3'b000;
        cycle();
        p0_SrcA = 32'd9; p0_SrcB = 32'd4; p0_ALUControl = 3'b001;
        p1_req_valid = 1; p1_SrcA = $urandom; p1_SrcB = $urandom; p1_ALUControl = 3'b011;
        for (int k = 0; k < 4; k++) begin
            cycle();
            chk($sformatf("bp_p0_ready_%0d", k), 32'(last_g0), 32'd0);
            chk($sformatf("bp_p1_ready_%0d", k), 32'(last_g1), 32'd1);
            p1_SrcA = $urandom; p1_SrcB = $urandom; p1_ALUControl = 3'b010;
        end
        // Withdraw the pending port0 request. It must never be issued.
        p0_req_valid = 0; p1_req_valid = 0; p0_rsp_ready = 1;
        cycle();
        cycle();
        chk("withdrawn_p0_rsp_valid", 32'(p0_rsp_valid), 32'd0);

        // Signed slt, then an unsupported op code.
        p1_req_valid = 1; p1_SrcA = 32'hFFFF_FFFF; p1_SrcB = 32'd1; p1_ALUControl = 3'b101;
        cycle();
        chk("slt_result", p1_ALUResult, 32'd1);
        p1_SrcA = 32'd5; p1_SrcB = 32'd6; p1_ALUControl = 3'b111;
        cycle();
        chk("op111_result", p1_ALUResult, 32'd0);
        chk("op111_zero", 32'(p1_Zero), 32'd1);
        idle(3);

        chk("q0_drained", 32'(q0.size()), 32'd0);
        chk("q1_drained", 32'(q1.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
